// File: rtl/v_block_scanner.sv
// v_block_scanner: vertical line/block scanner for the backlight dimming path.
// Counts enabled line edges after reset, skips a top offset, then walks the
// active area as NUM_BLOCKS bands of BLOCK_LINES lines, flagging block starts
// and a sticky end-of-frame.
module v_block_scanner #(
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned V_OFFSET    = 37,
   parameter int unsigned BLOCK_LINES = 72,
   parameter int unsigned NUM_BLOCKS  = 15,
   parameter int unsigned DUTY_W      = 7,
   parameter int unsigned BLK_W       = 4
) (
   input  logic              iHSYNC_clk,
   input  logic              iVSYNC_rst,
   input  logic              iEnable,
   output logic [CNT_W-1:0]  oV_Count,
   output logic [DUTY_W-1:0] oV_Block_Duty_Count,
   output logic [BLK_W-1:0]  oV_Block_Index,
   output logic              oBlock_Start,
   output logic              oActive,
   output logic              oFrame_Done
);

   // Parameter legality, evaluated at elaboration time.
   localparam longint unsigned CNT_MAX_L  = (64'd1 << CNT_W) - 64'd1;
   localparam longint unsigned FRAME_LEN  = 64'(V_OFFSET) + 64'(NUM_BLOCKS) * 64'(BLOCK_LINES);
   localparam int unsigned     DUTY_NEED  = 32'($clog2(BLOCK_LINES));
   localparam int unsigned     BLK_NEED   = 32'($clog2(NUM_BLOCKS));

   localparam bit PARAMS_OK = (CNT_W >= 32'd1) && (CNT_W <= 32'd63) &&
                              (V_OFFSET >= 32'd1) &&
                              (BLOCK_LINES >= 32'd2) &&
                              (NUM_BLOCKS >= 32'd1) &&
                              (DUTY_W >= DUTY_NEED) && (DUTY_W >= 32'd1) &&
                              (BLK_W >= BLK_NEED) && (BLK_W >= 32'd1) &&
                              (FRAME_LEN <= CNT_MAX_L);

   if (!PARAMS_OK) begin : g_param_error
      $error("v_block_scanner: illegal parameter combination");
   end

   // Terminal values used by the walk.
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]  OFFSET_END = CNT_W'(V_OFFSET - 32'd1);
   localparam logic [DUTY_W-1:0] DUTY_LAST  = DUTY_W'(BLOCK_LINES - 32'd1);
   localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(NUM_BLOCKS - 32'd1);

   typedef enum logic [1:0] {
      S_OFFSET = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [DUTY_W-1:0]   duty_q,   duty_d;
   logic [BLK_W-1:0]    idx_q,    idx_d;
   logic                start_q,  start_d;
   logic                active_q, active_d;
   logic                done_q,   done_d;

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge iHSYNC_clk or posedge iVSYNC_rst) begin
      if (iVSYNC_rst) begin
         state_q  <= S_OFFSET;
         cnt_q    <= '0;
         duty_q   <= '0;
         idx_q    <= '0;
         start_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         idx_q    <= idx_d;
         start_q  <= start_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // Next-state and next-output logic; a hold edge only drops the start pulse.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      duty_d   = duty_q;
      idx_d    = idx_q;
      start_d  = 1'b0;
      active_d = active_q;
      done_d   = done_q;

      if (iEnable) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

         unique case (state_q)
            S_OFFSET: begin
               duty_d   = '0;
               idx_d    = '0;
               active_d = 1'b0;
               if (cnt_q == OFFSET_END) begin
                  state_d  = S_ACTIVE;
                  active_d = 1'b1;
                  start_d  = 1'b1;
               end
            end
            S_ACTIVE: begin
               if (duty_q != DUTY_LAST) begin
                  duty_d = duty_q + DUTY_W'(1);
               end else if (idx_q != BLK_LAST) begin
                  duty_d  = '0;
                  idx_d   = idx_q + BLK_W'(1);
                  start_d = 1'b1;
               end else begin
                  state_d  = S_DONE;
                  duty_d   = '0;
                  active_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
            S_DONE: begin
               // Frame finished; only the line counter keeps moving.
            end
            default: begin
               state_d = S_OFFSET;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   assign oV_Count            = cnt_q;
   assign oV_Block_Duty_Count = duty_q;
   assign oV_Block_Index      = idx_q;
   assign oBlock_Start        = start_q;
   assign oActive             = active_q;
   assign oFrame_Done         = done_q;

endmodule

// File: tb/tb_v_block_scanner.sv
// Bench for v_block_scanner: three instances (defaults, small saturating
// counter, minimal frame), each checked edge by edge against an analytic model.
module tb_v_block_scanner;

   typedef struct packed {
      logic [31:0] cnt;
      logic [31:0] duty;
      logic [31:0] idx;
      logic        start;
      logic        active;
      logic        done;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic en_a, en_b, en_c;

   // Instance A: default parameters
   logic [11:0] cnt_a;  logic [6:0] duty_a; logic [3:0] idx_a;
   logic        st_a, act_a, done_a;
   // Instance B: 4-bit saturating counter
   logic [3:0]  cnt_b;  logic [0:0] duty_b; logic [1:0] idx_b;
   logic        st_b, act_b, done_b;
   // Instance C: minimal frame
   logic [11:0] cnt_c;  logic [0:0] duty_c; logic [0:0] idx_c;
   logic        st_c, act_c, done_c;

   v_block_scanner u_a (
      .iHSYNC_clk(clk), .iVSYNC_rst(rst_a), .iEnable(en_a),
      .oV_Count(cnt_a), .oV_Block_Duty_Count(duty_a), .oV_Block_Index(idx_a),
      .oBlock_Start(st_a), .oActive(act_a), .oFrame_Done(done_a));

   v_block_scanner #(.CNT_W(4), .V_OFFSET(2), .BLOCK_LINES(2), .NUM_BLOCKS(3),
                     .DUTY_W(1), .BLK_W(2)) u_b (
      .iHSYNC_clk(clk), .iVSYNC_rst(rst_b), .iEnable(en_b),
      .oV_Count(cnt_b), .oV_Block_Duty_Count(duty_b), .oV_Block_Index(idx_b),
      .oBlock_Start(st_b), .oActive(act_b), .oFrame_Done(done_b));

   v_block_scanner #(.CNT_W(12), .V_OFFSET(1), .BLOCK_LINES(2), .NUM_BLOCKS(1),
                     .DUTY_W(1), .BLK_W(1)) u_c (
      .iHSYNC_clk(clk), .iVSYNC_rst(rst_c), .iEnable(en_c),
      .oV_Count(cnt_c), .oV_Block_Duty_Count(duty_c), .oV_Block_Index(idx_c),
      .oBlock_Start(st_c), .oActive(act_c), .oFrame_Done(done_c));

   int total = 0;
   int bad   = 0;
   int n_a = 0, n_b = 0, n_c = 0;
   obs_t sb[$];
   obs_t got, exp_v;

   // Expected outputs after n enabled edges, derived from position in the frame.
   function automatic obs_t model(int n, int voff, int bl, int nb, int cmax, bit en);
      obs_t o;
      int   k;
      o = '0;
      o.cnt = 32'((n > cmax) ? cmax : n);
      if (n >= voff) begin
         k = n - voff;
         if (k < nb * bl) begin
            o.active = 1'b1;
            o.idx    = 32'(k / bl);
            o.duty   = 32'(k % bl);
            o.start  = en && ((k % bl) == 0);
         end else begin
            o.done = 1'b1;
            o.idx  = 32'(nb - 1);
         end
      end
      return o;
   endfunction

   function automatic obs_t sample_a();
      obs_t o;
      o = '{cnt: 32'(cnt_a), duty: 32'(duty_a), idx: 32'(idx_a),
            start: st_a, active: act_a, done: done_a};
      return o;
   endfunction

   function automatic obs_t sample_b();
      obs_t o;
      o = '{cnt: 32'(cnt_b), duty: 32'(duty_b), idx: 32'(idx_b),
            start: st_b, active: act_b, done: done_b};
      return o;
   endfunction

   function automatic obs_t sample_c();
      obs_t o;
      o = '{cnt: 32'(cnt_c), duty: 32'(duty_c), idx: 32'(idx_c),
            start: st_c, active: act_c, done: done_c};
      return o;
   endfunction

   // One line edge on each instance: drive, push expectation, settle.
   task automatic edge_a(input bit en);
      @(negedge clk);
      en_a = en;
      if (en) n_a++;
      sb.push_back(model(n_a, 37, 72, 15, 4095, en));
      @(posedge clk);
      #1;
      en_a = 1'b0;
   endtask

   task automatic edge_b(input bit en);
      @(negedge clk);
      en_b = en;
      if (en) n_b++;
      sb.push_back(model(n_b, 2, 2, 3, 15, en));
      @(posedge clk);
      #1;
      en_b = 1'b0;
   endtask

   task automatic edge_c(input bit en);
      @(negedge clk);
      en_c = en;
      if (en) n_c++;
      sb.push_back(model(n_c, 1, 2, 1, 4095, en));
      @(posedge clk);
      #1;
      en_c = 1'b0;
   endtask

   task automatic pulse_reset_a();
      @(negedge clk);
      rst_a = 1'b1;
      n_a   = 0;
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sb.push_back('0); sb.push_back('0); sb.push_back('0);
      for (int i = 0; i < 3; i++) begin
         exp_v = sb.pop_front();
         got   = (i == 0) ? sample_a() : (i == 1) ? sample_b() : sample_c();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL reset inst=%0d got=%h required=%h", i, got, exp_v);
         end
      end
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
   endtask

   task automatic test_first_block();
      for (int i = 0; i < 40; i++) begin
         edge_a(1'b1);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL first_block n=%0d got=%h required=%h", n_a, got, exp_v);
         end
      end
      total++;
      if (duty_a !== 7'd3 || act_a !== 1'b1) begin
         bad++;
         $display("FAIL first_block_edge40 duty=%0d active=%b required duty=3 active=1", duty_a, act_a);
      end
   endtask

   task automatic test_hold_on_start();
      while (n_a < 109) begin
         edge_a(1'b1);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL hold_pre n=%0d got=%h required=%h", n_a, got, exp_v);
         end
      end
      for (int i = 0; i < 6; i++) begin
         edge_a(i == 5);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL hold n=%0d step=%0d got=%h required=%h", n_a, i, got, exp_v);
         end
      end
      total++;
      if (cnt_a !== 12'd110 || duty_a !== 7'd1 || idx_a !== 4'd1) begin
         bad++;
         $display("FAIL hold_resume cnt=%0d duty=%0d idx=%0d required 110/1/1", cnt_a, duty_a, idx_a);
      end
   endtask

   task automatic test_full_frame();
      while (n_a < 1200) begin
         edge_a(1'b1);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL full_frame n=%0d got=%h required=%h", n_a, got, exp_v);
         end
      end
      total++;
      if (cnt_a !== 12'd1200 || done_a !== 1'b1 || act_a !== 1'b0 ||
          idx_a !== 4'd14 || duty_a !== 7'd0) begin
         bad++;
         $display("FAIL frame_end cnt=%0d done=%b act=%b idx=%0d duty=%0d required 1200/1/0/14/0",
                  cnt_a, done_a, act_a, idx_a, duty_a);
      end
   endtask

   task automatic test_reset_mid_block();
      pulse_reset_a();
      while (n_a < 427) begin
         edge_a(1'b1);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL mid_pre n=%0d got=%h required=%h", n_a, got, exp_v);
         end
      end
      total++;
      if (idx_a !== 4'd5 || duty_a !== 7'd30) begin
         bad++;
         $display("FAIL mid_position idx=%0d duty=%0d required 5/30", idx_a, duty_a);
      end
      @(negedge clk);
      #2;
      rst_a = 1'b1;
      n_a   = 0;
      sb.push_back('0);
      #1;
      exp_v = sb.pop_front();
      got   = sample_a();
      total++;
      if (got !== exp_v) begin
         bad++;
         $display("FAIL async_clear got=%h required=%h", got, exp_v);
      end
      @(negedge clk);
      rst_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         edge_a(1'b1);
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL mid_restart n=%0d got=%h required=%h", n_a, got, exp_v);
         end
      end
   endtask

   task automatic test_random_enable();
      pulse_reset_a();
      for (int i = 0; i < 300; i++) begin
         edge_a(1'($urandom_range(0, 1)));
         exp_v = sb.pop_front();
         got   = sample_a();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL random_en n=%0d step=%0d got=%h required=%h", n_a, i, got, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         edge_b(1'b1);
         exp_v = sb.pop_front();
         got   = sample_b();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL saturation n=%0d got=%h required=%h", n_b, got, exp_v);
         end
      end
      total++;
      if (cnt_b !== 4'd15 || done_b !== 1'b1 || idx_b !== 2'd2) begin
         bad++;
         $display("FAIL saturation_end cnt=%0d done=%b idx=%0d required 15/1/2", cnt_b, done_b, idx_b);
      end
   endtask

   task automatic test_min_frame();
      for (int i = 0; i < 5; i++) begin
         edge_c(1'b1);
         exp_v = sb.pop_front();
         got   = sample_c();
         total++;
         if (got !== exp_v) begin
            bad++;
            $display("FAIL min_frame n=%0d got=%h required=%h", n_c, got, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_block();
      test_hold_on_start();
      test_full_frame();
      test_reset_mid_block();
      test_random_enable();
      test_saturation();
      test_min_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/v_block_scanner.md
# v_block_scanner

Parametrised vertical line/block scanner for the dynamic backlight dimming path. Counts HSYNC-rate lines after each VSYNC, skips a programmable top offset, then walks the active area as NUM_BLOCKS bands of BLOCK_LINES lines each. It outputs the line-in-block duty count, the current block index, a block-start pulse, an active flag and a sticky frame-done flag. These drive per-block backlight duty generation downstream.

## Interface
Parameters:
- CNT_W, 12, line counter width
- V_OFFSET, 37, lines after reset before the first block line; must be ≥1
- BLOCK_LINES, 72, lines per block; must be ≥2
- NUM_BLOCKS, 15, blocks per frame; must be ≥1
- DUTY_W, 7, duty counter width; must be ≥ clog2(BLOCK_LINES)
- BLK_W, 4, block index width; must be ≥ clog2(NUM_BLOCKS)

Ports:
- iHSYNC_clk  in  1  line clock; all state changes on its rising edge
- iVSYNC_rst  in  1  reset, asynchronous, active-high
- iEnable  in  1  line qualifier; an edge with iEnable=0 is a hold edge
- oV_Count  out  CNT_W  lines since reset, saturating
- oV_Block_Duty_Count  out  DUTY_W  line within current block, 0..BLOCK_LINES-1
- oV_Block_Index  out  BLK_W  current block, 0..NUM_BLOCKS-1
- oBlock_Start  out  1  high for the line interval holding line 0 of a block
- oActive  out  1  high while inside the block area
- oFrame_Done  out  1  sticky; set after the last line of the last block

## Operation
- All outputs are registered. Reset (async, immediate, including mid-frame) sets every output to 0 and the state to OFFSET.
- oV_Count: +1 on every enabled edge and saturates at 2^CNT_W-1 (it does not wrap). It keeps counting in every state.
- OFFSET state: duty=0, index=0, oActive=0.
  - On the enabled edge where oV_Count (pre-edge) == V_OFFSET-1, the state moves to ACTIVE.
  - On that edge: duty=0, index=0, oActive=1, oBlock_Start=1.
- ACTIVE state, per enabled edge:
  - duty < BLOCK_LINES-1: duty+1, oBlock_Start=0.
  - duty == BLOCK_LINES-1 and index < NUM_BLOCKS-1: duty=0, index+1, oBlock_Start=1.
  - duty == BLOCK_LINES-1 and index == NUM_BLOCKS-1: state moves to DONE; duty=0, index holds at NUM_BLOCKS-1, oActive=0, oFrame_Done=1, oBlock_Start=0.
- DONE state: duty, index, oActive and oFrame_Done hold until reset. Only oV_Count advances.
- Hold edge (iEnable=0): every register holds except oBlock_Start, which is forced to 0. State transitions are evaluated only on enabled edges.
- Elaboration check: V_OFFSET + NUM_BLOCKS*BLOCK_LINES ≤ 2^CNT_W-1. Any violation or any parameter-constraint violation is an elaboration error.

## Timing
- Latency: outputs reflect the state after the most recent enabled edge. There is no combinational path from any input to any output.
- With the defaults, counting 1-based enabled edges after reset deassertion:
  - Edge 37: oV_Count=37, oActive=1, oBlock_Start=1, duty=0.
  - Edge 38: duty=1.
  - Edge 108: duty=71.
  - Edge 109: duty=0, index=1, oBlock_Start=1.
- Last active line, default parameters:
  - Edge 1116: index=14, duty=71, oV_Count=1116.
  - Edge 1117: DONE, oFrame_Done=1, oActive=0.
- Reset asserted between edges: outputs clear without a clock. The first enabled edge after release gives oV_Count=1.
- Reset deasserted near a clock edge: synchronised by the integrating level. The block adds no synchronizer.

## Test plan
- Defaults, 40 enabled edges after reset → oActive rises at edge 37 with duty=0; oBlock_Start high only at edge 37; duty=3 at edge 40.
- Defaults, 1200 edges → index steps 0..14 at edges 37+72k; oFrame_Done=1 and oActive=0 from edge 1117; duty=0 and index=14 held; oV_Count=1200.
- iEnable=0 for 5 edges while oBlock_Start=1 → oBlock_Start drops to 0 on the first hold edge; oV_Count, duty and index unchanged; counting resumes on re-enable with no skipped line.
- CNT_W=4, V_OFFSET=2, BLOCK_LINES=2, NUM_BLOCKS=3, 20 edges → oV_Count saturates at 15; oFrame_Done set at edge 8.
- Reset pulse mid-block (index=5, duty=30) → all outputs 0 immediately; the next frame repeats the edge-37 behaviour exactly.
- V_OFFSET=1, BLOCK_LINES=2, NUM_BLOCKS=1 → edge 1: ACTIVE with oBlock_Start=1; edge 2: duty=1; edge 3: DONE.
